// File: rtl/usb_uart_bridge_pkg.sv
// usb_uart_bridge_pkg: register map and bit positions shared
// by the bus bridge, its FIFO and anything that talks to them.
package usb_uart_bridge_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd2;
  localparam logic [1:0] ADDR_RX_CNT = 2'd3;

  localparam int ST_RX_NE    = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_OVF   = 2;
  localparam int ST_TX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;

  localparam int IEN_RX = 0;
  localparam int IEN_TX = 1;

  function automatic logic [7:0] sat8(input logic [8:0] v);
    return (v > 9'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/usb_uart_sync_fifo.sv
// usb_uart_sync_fifo: single-clock show-ahead FIFO with occupancy count.
// Push on full and pop on empty are ignored using pre-cycle state.
module usb_uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Head is forced to zero when empty so stale data never leaks out.
  assign o_dout = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/usb_uart_bus_bridge.sv
// usb_uart_bus_bridge: CPU register interface in front of a USB serial
// core byte stream, with TX/RX FIFOs, sticky overflow flags and an irq.
module usb_uart_bus_bridge
  import usb_uart_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [1:0] bus_addr,
  input  logic       bus_wr_en,
  input  logic [7:0] bus_wr_data,
  input  logic       bus_rd_en,
  output logic [7:0] bus_rd_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  r_rd_data;
  logic [1:0]  r_irq_en;
  logic        r_tx_ovf;
  logic        r_rx_ovf;
  logic        r_irq;

  logic        w_wr_data;
  logic        w_wr_status;
  logic        w_wr_ien;
  logic        w_rd_data;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_tx_pop;
  logic [7:0]  w_tx_dout;
  logic [AW:0] w_tx_count;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic        w_rx_push;
  logic [7:0]  w_rx_dout;
  logic [AW:0] w_rx_count;
  logic        w_tx_ovf_set;
  logic        w_rx_ovf_set;
  logic [7:0]  w_status;
  logic [7:0]  w_rd_mux;
  logic        w_irq_next;

  assign w_wr_data   = bus_wr_en && (bus_addr == ADDR_DATA);
  assign w_wr_status = bus_wr_en && (bus_addr == ADDR_STATUS);
  assign w_wr_ien    = bus_wr_en && (bus_addr == ADDR_IRQ_EN);
  assign w_rd_data   = bus_rd_en && (bus_addr == ADDR_DATA);

  assign w_tx_pop     = !w_tx_empty && tx_ready;
  assign w_rx_push    = rx_valid && !w_rx_full;
  assign w_tx_ovf_set = w_wr_data && w_tx_full;
  assign w_rx_ovf_set = rx_valid && w_rx_full;

  usb_uart_sync_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk   (clk_48mhz),
    .i_rst   (reset),
    .i_push  (w_wr_data),
    .i_din   (bus_wr_data),
    .i_pop   (w_tx_pop),
    .o_dout  (w_tx_dout),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  usb_uart_sync_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .i_clk   (clk_48mhz),
    .i_rst   (reset),
    .i_push  (w_rx_push),
    .i_din   (rx_data),
    .i_pop   (w_rd_data),
    .o_dout  (w_rx_dout),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  always_comb begin
    w_status              = '0;
    w_status[ST_RX_NE]    = !w_rx_empty;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_RX_OVF]   = r_rx_ovf;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_TX_OVF]   = r_tx_ovf;
  end

  always_comb begin
    w_rd_mux = '0;
    unique case (bus_addr)
      ADDR_DATA:   w_rd_mux = w_rx_dout;
      ADDR_STATUS: w_rd_mux = w_status;
      ADDR_IRQ_EN: w_rd_mux = {6'b0, r_irq_en};
      ADDR_RX_CNT: w_rd_mux = sat8(9'(w_rx_count));
      default:     w_rd_mux = '0;
    endcase
  end

  assign w_irq_next = (r_irq_en[IEN_RX] && !w_rx_empty) ||
                      (r_irq_en[IEN_TX] && w_tx_empty);

  // Sticky flags: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_tx_ovf  <= 1'b0;
      r_rx_ovf  <= 1'b0;
      r_irq_en  <= '0;
      r_irq     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_tx_ovf_set)
        r_tx_ovf <= 1'b1;
      else if (w_wr_status && bus_wr_data[ST_TX_OVF])
        r_tx_ovf <= 1'b0;
      if (w_rx_ovf_set)
        r_rx_ovf <= 1'b1;
      else if (w_wr_status && bus_wr_data[ST_RX_OVF])
        r_rx_ovf <= 1'b0;
      if (w_wr_ien) begin
        r_irq_en[IEN_RX] <= bus_wr_data[IEN_RX];
        r_irq_en[IEN_TX] <= bus_wr_data[IEN_TX];
      end
      r_irq <= w_irq_next;
      if (bus_rd_en) r_rd_data <= w_rd_mux;
    end
  end

  assign bus_rd_data = r_rd_data;
  assign tx_data     = w_tx_dout;
  assign tx_valid    = !w_tx_empty;
  assign rx_ready    = !w_rx_full;
  assign irq         = r_irq;

endmodule

// File: tb/tb_usb_uart_bus_bridge.sv
// tb_usb_uart_bus_bridge: directed and random stimulus against a
// queue-based model of the bridge register map and FIFOs.
module tb_usb_uart_bus_bridge;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] bus_addr;
  logic       bus_wr_en;
  logic [7:0] bus_wr_data;
  logic       bus_rd_en;
  logic [7:0] bus_rd_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       irq;

  always #10 clk = ~clk;

  usb_uart_bus_bridge #(.FIFO_DEPTH(D)) dut (
    .clk_48mhz   (clk),
    .reset       (reset),
    .bus_addr    (bus_addr),
    .bus_wr_en   (bus_wr_en),
    .bus_wr_data (bus_wr_data),
    .bus_rd_en   (bus_rd_en),
    .bus_rd_data (bus_rd_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .irq         (irq)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       m_tx_ovf;
  logic       m_rx_ovf;
  logic [1:0] m_ien;
  logic [7:0] m_rd;
  logic       m_irq;
  logic       g_tr;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] status_m();
    return {3'b000, m_tx_ovf, 1'(txq.size() == 0), m_rx_ovf,
            1'(txq.size() == D), 1'(rxq.size() != 0)};
  endfunction

  // One clock: drive at negedge, predict from pre-edge model, check next negedge.
  task automatic step(input logic wr, input logic rd,
                      input logic [1:0] a, input logic [7:0] wd,
                      input logic rv, input logic [7:0] rvd,
                      input logic tr);
    logic tx_ne;
    logic rx_ne;
    logic tx_fu;
    logic rx_fu;
    int   n;
    bus_wr_en   = wr;
    bus_rd_en   = rd;
    bus_addr    = a;
    bus_wr_data = wd;
    rx_valid    = rv;
    rx_data     = rvd;
    tx_ready    = tr;
    tx_ne = txq.size() != 0;
    rx_ne = rxq.size() != 0;
    tx_fu = txq.size() == D;
    rx_fu = rxq.size() == D;
    m_irq = (m_ien[0] && rx_ne) || (m_ien[1] && !tx_ne);
    if (rd) begin
      if (a == 2'd0) m_rd = rx_ne ? rxq[0] : 8'h00;
      else if (a == 2'd1) m_rd = status_m();
      else if (a == 2'd2) m_rd = {6'b0, m_ien};
      else begin
        n = rxq.size();
        m_rd = (n > 255) ? 8'hFF : 8'(n);
      end
    end
    if (wr && a == 2'd1) begin
      if (wd[2]) m_rx_ovf = 1'b0;
      if (wd[4]) m_tx_ovf = 1'b0;
    end
    if (wr && a == 2'd2) m_ien = wd[1:0];
    if (tr && tx_ne) void'(txq.pop_front());
    if (wr && a == 2'd0) begin
      if (tx_fu) m_tx_ovf = 1'b1;
      else txq.push_back(wd);
    end
    if (rd && a == 2'd0 && rx_ne) void'(rxq.pop_front());
    if (rv) begin
      if (rx_fu) m_rx_ovf = 1'b1;
      else rxq.push_back(rvd);
    end
    @(negedge clk);
    bus_wr_en = 1'b0;
    bus_rd_en = 1'b0;
    rx_valid  = 1'b0;
    chk("rd_data", bus_rd_data, m_rd);
    chk("irq", irq, m_irq);
    chk("tx_valid", tx_valid, 1'(txq.size() != 0));
    if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
    chk("rx_ready", rx_ready, 1'(rxq.size() != D));
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, 1'b0, a, d, 1'b0, 8'h00, g_tr);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b0, 1'b1, a, 8'h00, 1'b0, 8'h00, g_tr);
  endtask

  task automatic rx(input logic [7:0] d);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, d, g_tr);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, g_tr);
  endtask

  task automatic do_reset(input logic with_strobes);
    reset = 1'b1;
    if (with_strobes) begin
      bus_wr_en   = 1'b1;
      bus_addr    = 2'd0;
      bus_wr_data = 8'hEE;
      bus_rd_en   = 1'b1;
    end
    @(negedge clk);
    reset     = 1'b0;
    bus_wr_en = 1'b0;
    bus_rd_en = 1'b0;
    txq.delete();
    rxq.delete();
    m_tx_ovf = 1'b0;
    m_rx_ovf = 1'b0;
    m_ien    = 2'b00;
    m_rd     = 8'h00;
    m_irq    = 1'b0;
    chk("rst_rd_data", bus_rd_data, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rx_ready", rx_ready, 1'b1);
    chk("rst_irq", irq, 1'b0);
  endtask

  initial begin
    int         op;
    logic [7:0] first;
    reset       = 1'b1;
    bus_addr    = 2'd0;
    bus_wr_en   = 1'b0;
    bus_wr_data = 8'h00;
    bus_rd_en   = 1'b0;
    tx_ready    = 1'b0;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    g_tr        = 1'b0;
    repeat (2) @(negedge clk);
    do_reset(1'b0);
    rd(2'd1);
    chk("st_reset", bus_rd_data, 8'h08);

    // Two writes drain back-to-back; one RX byte parked for STATUS 0x09.
    rx(8'h3C);
    g_tr = 1'b1;
    wr(2'd0, 8'h41);
    chk("tx_first", tx_data, 8'h41);
    wr(2'd0, 8'h42);
    chk("tx_second", tx_data, 8'h42);
    idle();
    rd(2'd1);
    chk("st_09", bus_rd_data, 8'h09);
    rd(2'd0);

    // TX fill and overflow with a stalled sink.
    g_tr  = 1'b0;
    first = 8'($urandom);
    wr(2'd0, first);
    for (int i = 0; i < 16; i++) wr(2'd0, 8'($urandom));
    chk("tx_held", tx_data, first);
    rd(2'd1);
    chk("st_tx_full", bus_rd_data[1], 1'b1);
    chk("st_tx_ovf", bus_rd_data[4], 1'b1);
    wr(2'd1, 8'h10);
    rd(2'd1);
    chk("st_tx_ovf_clr", bus_rd_data[4], 1'b0);
    step(1'b1, 1'b0, 2'd0, 8'h77, 1'b0, 8'h00, 1'b1);
    rd(2'd1);
    chk("st_full_pushpop", bus_rd_data[4], 1'b1);
    wr(2'd1, 8'h10);
    for (int i = 0; i < 80 && txq.size() != 0; i++)
      step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'($urandom));
    chk("tx_drained", tx_valid, 1'b0);

    // RX basic path and empty read.
    rx(8'h55);
    rx(8'hAA);
    rd(2'd3);
    chk("rx_cnt2", bus_rd_data, 8'h02);
    rd(2'd0);
    chk("rx_55", bus_rd_data, 8'h55);
    rd(2'd0);
    chk("rx_AA", bus_rd_data, 8'hAA);
    rd(2'd0);
    chk("rx_empty_rd", bus_rd_data, 8'h00);
    step(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 8'h5A, g_tr);
    chk("rx_empty_pushpop", bus_rd_data, 8'h00);
    rd(2'd0);
    chk("rx_5A", bus_rd_data, 8'h5A);

    // RX overflow, set-wins, push+pop on full.
    for (int i = 0; i < 17; i++) rx(8'($urandom));
    chk("rx_ready_low", rx_ready, 1'b0);
    rd(2'd1);
    chk("st_rx_ovf", bus_rd_data[2], 1'b1);
    rd(2'd3);
    chk("rx_cnt16", bus_rd_data, 8'h10);
    wr(2'd1, 8'h04);
    step(1'b1, 1'b0, 2'd1, 8'h04, 1'b1, 8'hC3, g_tr);
    rd(2'd1);
    chk("st_set_wins", bus_rd_data[2], 1'b1);
    step(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 8'h99, g_tr);
    wr(2'd1, 8'h04);
    rd(2'd1);
    chk("st_rx_ovf_clr", bus_rd_data[2], 1'b0);
    repeat (16) rd(2'd0);
    chk("rx_drained", rx_ready, 1'b1);

    // Interrupts.
    wr(2'd2, 8'hFD);
    rd(2'd2);
    chk("ien_rb", bus_rd_data, 8'h01);
    rx(8'h77);
    idle();
    chk("irq_rx_hi", irq, 1'b1);
    rd(2'd0);
    chk("irq_hold", irq, 1'b1);
    idle();
    chk("irq_rx_lo", irq, 1'b0);
    wr(2'd2, 8'h02);
    idle();
    chk("irq_tx_empty", irq, 1'b1);
    wr(2'd2, 8'h00);
    idle();

    // Random mixed traffic.
    for (int i = 0; i < 600; i++) begin
      op = int'($urandom_range(0, 7));
      unique case (op)
        0, 1: step(1'b1, 1'b0, 2'd0, 8'($urandom), 1'($urandom),
                   8'($urandom), 1'($urandom_range(0, 3) == 0));
        2, 3: step(1'b0, 1'b1, 2'd0, 8'h00, 1'($urandom),
                   8'($urandom), 1'($urandom_range(0, 3) == 0));
        4:    step(1'b0, 1'b1, 2'($urandom_range(1, 3)), 8'h00,
                   1'($urandom), 8'($urandom), 1'($urandom));
        5:    step(1'b1, 1'b0, 2'd1, 8'($urandom), 1'($urandom),
                   8'($urandom), 1'($urandom));
        6:    step(1'b1, 1'b0, 2'd2, 8'($urandom), 1'($urandom),
                   8'($urandom), 1'($urandom));
        default: step(1'b0, 1'b0, 2'd0, 8'h00, 1'($urandom),
                      8'($urandom), 1'($urandom));
      endcase
    end

    // Reset in the middle of a stalled TX handshake.
    do_reset(1'b0);
    g_tr = 1'b0;
    for (int i = 0; i < 5; i++) wr(2'd0, 8'($urandom));
    chk("stall_valid", tx_valid, 1'b1);
    do_reset(1'b1);
    g_tr = 1'b1;
    idle();
    chk("post_rst_valid", tx_valid, 1'b0);
    rd(2'd1);
    chk("post_rst_st", bus_rd_data, 8'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
